bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of each data word.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the width of each address.
REQ-003 Parameter NUM_CLIENTS, default 4, SHALL set the number of requesting clients (2..8).
REQ-004 Parameter TIMEOUT, default 16, SHALL set the maximum number of BUSY cycles to wait for slv_ack.
REQ-005 Ports SHALL be:
  clk  in  1  single clock, all state updates on rising edge.
  reset  in  1  asynchronous, active-low reset.
  client_rq  in  NUM_CLIENTS  per-client request, held until client_ack.
  client_wr_ni  in  NUM_CLIENTS  per-client direction, 1 = write, 0 = read.
  client_address  in  NUM_CLIENTS*ADDR_WIDTH  packed addresses; client i at slice i.
  client_dataW  in  NUM_CLIENTS*DATA_WIDTH  packed write data; client i at slice i.
  client_ack  out  NUM_CLIENTS  one-hot, one-cycle completion pulse.
  client_dataR  out  DATA_WIDTH  read data, broadcast, valid while client_ack is high.
  slv_rq  out  1  request to the shared slave.
  slv_wr_ni  out  1  forwarded direction.
  slv_address  out  ADDR_WIDTH  forwarded address.
  slv_dataW  out  DATA_WIDTH  forwarded write data.
  slv_ack  in  1  slave completion, single cycle.
  slv_dataR  in  DATA_WIDTH  slave read data, valid with slv_ack.
  err_timeout  out  1  one-cycle pulse on slave timeout.

Function
REQ-006 The FSM SHALL have three states: IDLE, BUSY and ACK.
REQ-007 In IDLE with any client_rq bit set, the block SHALL latch a grant index and enter BUSY on the next edge.
REQ-008 The grant SHALL be round-robin: search starts at last_grant+1 and wraps modulo NUM_CLIENTS; lowest index wins when last_grant = NUM_CLIENTS-1.
REQ-009 In BUSY, slv_rq SHALL be 1 and slv_wr_ni/slv_address/slv_dataW SHALL equal the granted client's slices; in IDLE and ACK they SHALL be 0.
REQ-010 In BUSY, slv_ack=1 SHALL capture slv_dataR into a read register (reads only; hold the value on writes) and move to ACK.
REQ-011 In ACK, client_ack[grant] SHALL be 1 for exactly one cycle, client_dataR SHALL drive the read register, last_grant SHALL take grant, and the next state SHALL be IDLE.
REQ-012 Latency: grant to client_ack SHALL be slave latency + 2 cycles; minimum request-to-ack is 3 cycles with zero-wait slv_ack.
REQ-013 A client still requesting in IDLE after its ack SHALL be re-granted only if no other client requests (back-to-back allowed).
REQ-014 If client_rq[grant] drops during BUSY (protocol violation), the FSM SHALL return to IDLE next cycle, assert no client_ack, and leave last_grant unchanged.
REQ-015 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle without slv_ack.
REQ-016 When the wait counter reaches TIMEOUT, the block SHALL pulse err_timeout for one cycle, return to IDLE, set last_grant = grant, and assert no client_ack.
REQ-017 If slv_ack and a timeout occur in the same cycle, slv_ack SHALL win.
REQ-018 slv_ack outside BUSY SHALL be ignored.

Reset
REQ-019 While reset=0: state = IDLE; last_grant = NUM_CLIENTS-1; wait counter, read register and all outputs = 0.
REQ-020 Reset asserted mid-transaction SHALL abort it immediately (slv_rq low asynchronously) with no ack or error pulse after release.

Structure
REQ-021 Package bus_arb_pkg SHALL hold the state encoding (IDLE=0, BUSY=1, ACK=2) and the counter-width function clog2.
REQ-022 Round-robin selection SHALL be a separate combinational sub-module rr_picker (inputs rq vector and last_grant; outputs valid and index).

Verification
REQ-023 Single read: client 2 rq, address 0x5, wr_ni=0; slv_ack after 1 cycle with dataR=0xA5 -> client_ack=4'b0100 for one cycle, client_dataR=0xA5.
REQ-024 Fairness: all four rq held continuously, zero-wait slave -> grant order 0,1,2,3,0, each ack 3 cycles apart.
REQ-025 Write forward: client 1 wr_ni=1, address 0x3, dataW=0x3C -> slv_address=0x3, slv_dataW=0x3C, slv_wr_ni=1 throughout BUSY.
REQ-026 Timeout: slv_ack never asserted, TIMEOUT=16 -> err_timeout pulse 16 cycles after BUSY entry, no client_ack, FSM in IDLE.
REQ-027 Abort: client 0 drops rq in the second BUSY cycle -> slv_rq low next cycle, no ack, the next grant is again searched from client 1.
REQ-028 Reset in BUSY: reset=0 for 2 cycles -> all outputs 0 immediately; after release, client 0 has priority.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter slice.
//   arb_state_t : FSM state encoding (IDLE=0, BUSY=1, ACK=2)
//   clog2       : ceiling log2 used to size index and counter registers
//                 (never returns less than 1 so vectors stay legal)
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >>> 1;
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   rq         : request vector, one bit per client
//   last_grant : index of the most recently served client
//   valid      : at least one request is pending
//   index      : first requesting client found when searching upward from
//                last_grant+1, wrapping modulo NUM_CLIENTS
module rr_picker #(
    parameter int NUM_CLIENTS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_CLIENTS-1:0] rq,
    input  logic [IDX_W-1:0]       last_grant,
    output logic                   valid,
    output logic [IDX_W-1:0]       index
);

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        valid = 1'b0;
        index = {IDX_W{1'b0}};
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            index = rq[(int'(last_grant) + 1 + k) % NUM_CLIENTS]
                  ? IDX_W'((int'(last_grant) + 1 + k) % NUM_CLIENTS)
                  : index;
            valid = valid | rq[(int'(last_grant) + 1 + k) % NUM_CLIENTS];
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave port among NUM_CLIENTS clients.
// A transaction runs IDLE -> BUSY (forward to slave) -> ACK (one-cycle
// client_ack). BUSY is left early on a client drop (abort, no ack) or
// when the wait counter reaches TIMEOUT (err_timeout pulse, no ack).
//   clk, reset      : clock, asynchronous active-low reset
//   client_*        : packed per-client request/direction/address/data in,
//                     one-hot ack and broadcast read data out
//   slv_*           : forwarded request to the shared slave and its response
//   err_timeout     : one-cycle pulse when the slave fails to answer
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_CLIENTS = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            client_rq,
    input  logic [NUM_CLIENTS-1:0]            client_wr_ni,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_address,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_dataW,
    output logic [NUM_CLIENTS-1:0]            client_ack,
    output logic [DATA_WIDTH-1:0]             client_dataR,
    output logic                              slv_rq,
    output logic                              slv_wr_ni,
    output logic [ADDR_WIDTH-1:0]             slv_address,
    output logic [DATA_WIDTH-1:0]             slv_dataW,
    input  logic                              slv_ack,
    input  logic [DATA_WIDTH-1:0]             slv_dataR,
    output logic                              err_timeout
);

    localparam int IDX_W = clog2(NUM_CLIENTS);
    localparam int CNT_W = clog2(TIMEOUT + 1);

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       r_last_grant;
    logic [CNT_W-1:0]       r_wait_cnt;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_err_timeout;
    logic                   w_pick_valid;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_timeout_hit;
    logic                   w_busy;
    logic                   w_in_ack;

    rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .rq         (client_rq),
        .last_grant (r_last_grant),
        .valid      (w_pick_valid),
        .index      (w_pick_idx)
    );

    // Next-state logic; slave ack beats both a client drop and a timeout.
    always_comb begin
        w_next_state  = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = BUSY;
                end else begin
                    w_next_state = IDLE;
                end
            end
            BUSY: begin
                if (slv_ack) begin
                    w_next_state = ACK;
                end else if (!client_rq[r_grant]) begin
                    w_next_state = IDLE;
                end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // This cycle's increment makes the counter reach TIMEOUT.
                    w_next_state  = IDLE;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_next_state = BUSY;
                end
            end
            ACK: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register and timeout pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_err_timeout <= w_timeout_hit;
        end
    end

    // Grant latch on IDLE exit; last_grant advances on completion or timeout, never on abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant      <= {IDX_W{1'b0}};
            r_last_grant <= IDX_W'(NUM_CLIENTS - 1);
        end else begin
            if (r_state == IDLE && w_pick_valid) begin
                r_grant <= w_pick_idx;
            end else begin
                r_grant <= r_grant;
            end
            if (r_state == ACK || w_timeout_hit) begin
                r_last_grant <= r_grant;
            end else begin
                r_last_grant <= r_last_grant;
            end
        end
    end

    // Wait counter: zero outside BUSY so it is clear on every BUSY entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end else if (r_state != BUSY) begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end else if (!slv_ack) begin
            r_wait_cnt <= r_wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // Read register: captures slave data only for reads completed in BUSY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= {DATA_WIDTH{1'b0}};
        end else if (r_state == BUSY && slv_ack && !client_wr_ni[r_grant]) begin
            r_rdata <= slv_dataR;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    // Outputs decode directly from state registers, so reset clears them at once.
    assign w_busy       = (r_state == BUSY);
    assign w_in_ack     = (r_state == ACK);
    assign slv_rq       = w_busy;
    assign slv_wr_ni    = w_busy ? client_wr_ni[r_grant] : 1'b0;
    assign slv_address  = w_busy ? client_address[int'(r_grant) * ADDR_WIDTH +: ADDR_WIDTH]
                                 : {ADDR_WIDTH{1'b0}};
    assign slv_dataW    = w_busy ? client_dataW[int'(r_grant) * DATA_WIDTH +: DATA_WIDTH]
                                 : {DATA_WIDTH{1'b0}};
    assign client_ack   = w_in_ack ? ({{(NUM_CLIENTS-1){1'b0}}, 1'b1} << r_grant)
                                   : {NUM_CLIENTS{1'b0}};
    assign client_dataR = w_in_ack ? r_rdata : {DATA_WIDTH{1'b0}};
    assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with default parameters.
module tb_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  client_rq;
    logic [3:0]  client_wr_ni;
    logic [15:0] client_address;
    logic [31:0] client_dataW;
    logic [3:0]  client_ack;
    logic [7:0]  client_dataR;
    logic        slv_rq;
    logic        slv_wr_ni;
    logic [3:0]  slv_address;
    logic [7:0]  slv_dataW;
    logic        slv_ack;
    logic [7:0]  slv_dataR;
    logic        err_timeout;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    bus_arbiter #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .NUM_CLIENTS (4),
        .TIMEOUT     (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .client_rq      (client_rq),
        .client_wr_ni   (client_wr_ni),
        .client_address (client_address),
        .client_dataW   (client_dataW),
        .client_ack     (client_ack),
        .client_dataR   (client_dataR),
        .slv_rq         (slv_rq),
        .slv_wr_ni      (slv_wr_ni),
        .slv_address    (slv_address),
        .slv_dataW      (slv_dataW),
        .slv_ack        (slv_ack),
        .slv_dataR      (slv_dataR),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance until a client_ack appears, at most 8 cycles.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (client_ack == 4'b0000 && n < 8);
    endtask

    initial begin
        int          n_wait;
        logic [3:0]  exp_ack;
        int          exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        reset          = 1'b1;
        client_rq      = 4'b0000;
        client_wr_ni   = 4'b0000;
        client_address = 16'h0000;
        client_dataW   = 32'h0000_0000;
        slv_ack        = 1'b0;
        slv_dataR      = 8'h00;
        #1 reset = 1'b0;
        #2;
        check("rst_slv_rq",   32'(slv_rq),       32'h0);
        check("rst_ack",      32'(client_ack),   32'h0);
        check("rst_err",      32'(err_timeout),  32'h0);
        check("rst_dataR",    32'(client_dataR), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single read from client 2, slave answers in the second BUSY cycle.
        client_address = 16'h0500;
        client_rq      = 4'b0100;
        tick();
        check("rd_busy_rq",   32'(slv_rq),      32'h1);
        check("rd_busy_addr", 32'(slv_address), 32'h5);
        check("rd_busy_wr",   32'(slv_wr_ni),   32'h0);
        tick();
        check("rd_wait_rq",   32'(slv_rq),      32'h1);
        check("rd_wait_ack",  32'(client_ack),  32'h0);
        slv_ack   = 1'b1;
        slv_dataR = 8'hA5;
        tick();
        slv_ack   = 1'b0;
        check("rd_ack",       32'(client_ack),   32'h4);
        check("rd_dataR",     32'(client_dataR), 32'hA5);
        check("rd_ack_slvrq", 32'(slv_rq),       32'h0);
        client_rq = 4'b0000;
        tick();
        check("rd_ack_pulse", 32'(client_ack),   32'h0);

        // Write forward from client 1; slave read data must not overwrite the read register.
        client_address = 16'h0030;
        client_dataW   = 32'h0000_3C00;
        client_wr_ni   = 4'b0010;
        client_rq      = 4'b0010;
        tick();
        check("wr_addr0",  32'(slv_address), 32'h3);
        check("wr_data0",  32'(slv_dataW),   32'h3C);
        check("wr_dir0",   32'(slv_wr_ni),   32'h1);
        tick();
        check("wr_addr1",  32'(slv_address), 32'h3);
        check("wr_data1",  32'(slv_dataW),   32'h3C);
        check("wr_dir1",   32'(slv_wr_ni),   32'h1);
        slv_ack   = 1'b1;
        slv_dataR = 8'h77;
        tick();
        slv_ack   = 1'b0;
        check("wr_ack",    32'(client_ack),   32'h2);
        check("wr_hold",   32'(client_dataR), 32'hA5);
        check("wr_ack_wr", 32'(slv_wr_ni),    32'h0);
        client_rq    = 4'b0000;
        client_wr_ni = 4'b0000;
        tick();

        // Reset in the middle of BUSY, then all clients requesting.
        client_address = 16'hDCBA;
        client_dataW   = 32'h4433_2211;
        client_rq      = 4'b0100;
        tick();
        check("rb_busy",   32'(slv_rq), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("rb_async_rq",   32'(slv_rq),      32'h0);
        check("rb_async_addr", 32'(slv_address), 32'h0);
        check("rb_async_data", 32'(slv_dataW),   32'h0);
        tick();
        check("rb_hold_rq",    32'(slv_rq),      32'h0);
        tick();
        check("rb_hold_ack",   32'(client_ack),  32'h0);
        reset     = 1'b1;
        client_rq = 4'b1111;
        slv_ack   = 1'b1;
        slv_dataR = 8'h5A;
        tick();
        check("rb_prio_addr",  32'(slv_address), 32'hA);
        check("rb_no_err",     32'(err_timeout), 32'h0);

        // Fairness with a zero-wait slave.
        for (int k = 0; k < 5; k++) begin
            wait_ack(n_wait);
            exp_ack = 4'b0001 << exp_order[k];
            check($sformatf("fair_grant%0d", k), 32'(client_ack), 32'(exp_ack));
            check($sformatf("fair_gap%0d", k), 32'(n_wait), (k == 0) ? 32'd1 : 32'd3);
        end
        check("fair_dataR", 32'(client_dataR), 32'h5A);
        client_rq = 4'b0000;
        slv_ack   = 1'b0;
        tick();
        check("fair_idle", 32'(slv_rq), 32'h0);

        // Timeout on client 3: slave never answers.
        client_rq = 4'b1000;
        tick();
        check("to_busy_addr", 32'(slv_address), 32'hD);
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("to_wait%0d", i), {30'd0, slv_rq, err_timeout}, 32'h2);
        end
        tick();
        check("to_err",     32'(err_timeout), 32'h1);
        check("to_idle",    32'(slv_rq),      32'h0);
        check("to_no_ack",  32'(client_ack),  32'h0);
        client_rq = 4'b0000;
        tick();
        check("to_pulse",   32'(err_timeout), 32'h0);
        check("to_stay",    32'(slv_rq),      32'h0);

        // Client 0 completes, is re-granted back-to-back, then drops mid-BUSY.
        client_rq = 4'b0001;
        slv_ack   = 1'b1;
        tick();
        tick();
        check("ab_first_ack", 32'(client_ack), 32'h1);
        slv_ack = 1'b0;
        tick();
        check("ab_idle_ack",  32'(client_ack),  32'h0);
        tick();
        check("ab_regrant",   32'(slv_address), 32'hA);
        tick();
        check("ab_busy2",     32'(slv_rq),      32'h1);
        client_rq = 4'b0000;
        tick();
        check("ab_drop_rq",   32'(slv_rq),      32'h0);
        check("ab_drop_ack",  32'(client_ack),  32'h0);
        tick();
        check("ab_after_ack", 32'(client_ack),  32'h0);
        check("ab_after_err", 32'(err_timeout), 32'h0);
        client_rq = 4'b1011;
        tick();
        check("ab_next_grant", 32'(slv_address), 32'hB);
        slv_ack = 1'b1;
        tick();
        check("ab_next_ack",   32'(client_ack),  32'h2);
        client_rq = 4'b0000;
        slv_ack   = 1'b0;
        tick();

        // Stray slave ack while idle is ignored.
        slv_ack   = 1'b1;
        slv_dataR = 8'hFF;
        tick();
        check("stray_ack",   32'(client_ack), 32'h0);
        check("stray_rq",    32'(slv_rq),     32'h0);
        slv_ack = 1'b0;
        tick();
        check("stray_dataR", 32'(client_dataR), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
